mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 77 +++++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus types, arbiter state encoding and payload mapping helpers
// for the ibus/dbus to cbus memory arbiter.
package mem_arbiter_pkg;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    D_ADDR,
    I_DATA,
    D_DATA
  } arb_state_t;

  // Instruction fetches are always full-word reads.
  function automatic cbus_req_t ibus_to_cbus(input ibus_req_t r);
    cbus_req_t c;
    c          = '0;
    c.valid    = r.valid;
    c.is_write = 1'b0;
    c.addr     = r.addr;
    c.size     = SIZE_WORD;
    return c;
  endfunction

  function automatic cbus_req_t dbus_to_cbus(input dbus_req_t r);
    cbus_req_t c;
    c.valid    = r.valid;
    c.is_write = |r.strobe;
    c.addr     = r.addr;
    c.size     = r.size;
    c.strobe   = r.strobe;
    c.data     = r.data;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one cbus port between ibus and dbus: one outstanding transaction,
// dbus priority, ibus starvation bounded by MAX_D_STREAK consecutive dbus grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  localparam int STREAK_W = ($clog2(MAX_D_STREAK + 1) < 3) ? 3 : $clog2(MAX_D_STREAK + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  ibus_req_t           ireq,
  output ibus_resp_t          iresp,
  input  dbus_req_t           dreq,
  output dbus_resp_t          dresp,
  output cbus_req_t           creq,
  input  cbus_resp_t          cresp,
  output arb_state_t          dbg_state_o,
  output logic [STREAK_W-1:0] dbg_streak_o
);

  // Handshake: a requester holds valid and payload stable until it sees
  // addr_ok; data_ok follows addr_ok by zero or more cycles and is routed
  // only to the owner. The non-owner always sees addr_ok = data_ok = 0.

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    creq     = '0;
    iresp    = '0;
    dresp    = '0;

    case (state_q)
      IDLE: begin
        if (dreq.valid && !(ireq.valid && streak_q >= STREAK_MAX)) grant_d = 1'b1;
        else if (ireq.valid)                                       grant_i = 1'b1;
      end
      I_ADDR: grant_i = 1'b1;
      D_ADDR: grant_d = 1'b1;
      I_DATA: begin
        if (cresp.data_ok) begin
          iresp.data_ok = 1'b1;
          iresp.data    = cresp.data;
          state_d       = IDLE;
        end
      end
      D_DATA: begin
        if (cresp.data_ok) begin
          dresp.data_ok = 1'b1;
          dresp.data    = cresp.data;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Owner stays locked on cbus until the memory accepts the address.
    if (grant_i) begin
      creq = ibus_to_cbus(ireq);
      if (cresp.addr_ok) begin
        iresp.addr_ok = 1'b1;
        streak_d      = '0;
        if (cresp.data_ok) begin
          iresp.data_ok = 1'b1;
          iresp.data    = cresp.data;
          state_d       = IDLE;
        end else begin
          state_d = I_DATA;
        end
      end else begin
        state_d = I_ADDR;
      end
    end

    if (grant_d) begin
      creq = dbus_to_cbus(dreq);
      if (cresp.addr_ok) begin
        dresp.addr_ok = 1'b1;
        if (!ireq.valid)                streak_d = '0;
        else if (streak_q < STREAK_MAX) streak_d = streak_q + 1'b1;
        if (cresp.data_ok) begin
          dresp.data_ok = 1'b1;
          dresp.data    = cresp.data;
          state_d       = IDLE;
        end else begin
          state_d = D_DATA;
        end
      end else begin
        state_d = D_ADDR;
      end
    end
  end

  assign dbg_state_o  = state_q;
  assign dbg_streak_o = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a transaction-level
// reference model and a combinational memory responder.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int  MAXS = 4;
  localparam byte CH_I = 8'h49;
  localparam byte CH_D = 8'h44;

  logic       clk = 1'b0;
  logic       resetn;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  arb_state_t dbg_state;
  logic [2:0] dbg_streak;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ireq        (ireq),
    .iresp       (iresp),
    .dreq        (dreq),
    .dresp       (dresp),
    .creq        (creq),
    .cresp       (cresp),
    .dbg_state_o (dbg_state),
    .dbg_streak_o(dbg_streak)
  );

  // Memory responder: one outstanding access, data derived from the address.
  logic        mem_aok = 1'b0, mem_dok = 1'b0, mem_same = 1'b0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr_q = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hbfc0_0000) + 32'h2408_0001;
  endfunction

  always_comb begin
    cresp = '0;
    if (mem_busy) begin
      if (mem_dok) begin
        cresp.data_ok = 1'b1;
        cresp.data    = mem_word(mem_addr_q);
      end
    end else if (creq.valid && mem_aok) begin
      cresp.addr_ok = 1'b1;
      if (mem_same) begin
        cresp.data_ok = 1'b1;
        cresp.data    = mem_word(creq.addr);
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          m_owner = 0;
  bit          m_accepted = 1'b0;
  int          m_streak = 0;
  logic [31:0] exp_q_i[$];
  logic [31:0] exp_q_d[$];
  byte         grant_log[$];
  cbus_req_t   s_creq;
  ibus_resp_t  s_iresp;
  dbus_resp_t  s_dresp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check at negedge, react after posedge.
  task automatic tick();
    bit          gi, gd, hs, dok, iack, dack, nb;
    int          ow;
    logic [31:0] na;
    cbus_req_t   ec;
    ibus_resp_t  ei;
    dbus_resp_t  ed;
    @(negedge clk);
    gi = 1'b0;
    gd = 1'b0;
    if (m_owner == 0) begin
      if (dreq.valid && !(ireq.valid && m_streak >= MAXS)) gd = 1'b1;
      else if (ireq.valid)                                 gi = 1'b1;
    end else if (!m_accepted) begin
      gi = (m_owner == 1);
      gd = (m_owner == 2);
    end
    ec = '0;
    if (gi) begin
      ec.valid = 1'b1;
      ec.addr  = ireq.addr;
      ec.size  = SIZE_WORD;
    end
    if (gd) begin
      ec.valid    = 1'b1;
      ec.is_write = |dreq.strobe;
      ec.addr     = dreq.addr;
      ec.size     = dreq.size;
      ec.strobe   = dreq.strobe;
      ec.data     = dreq.data;
    end
    chk("creq", 128'(creq), 128'(ec));
    hs = ec.valid && cresp.addr_ok;
    if (hs && gi) exp_q_i.push_back(mem_word(ec.addr));
    if (hs && gd) exp_q_d.push_back(mem_word(ec.addr));
    dok = cresp.data_ok && (hs || m_accepted);
    ow  = gi ? 1 : (gd ? 2 : m_owner);
    ei  = '0;
    ed  = '0;
    ei.addr_ok = hs && gi;
    ed.addr_ok = hs && gd;
    if (dok && ow == 1) begin
      ei.data_ok = 1'b1;
      ei.data    = (exp_q_i.size() != 0) ? exp_q_i.pop_front() : 32'hdead_0000;
    end
    if (dok && ow == 2) begin
      ed.data_ok = 1'b1;
      ed.data    = (exp_q_d.size() != 0) ? exp_q_d.pop_front() : 32'hdead_0000;
    end
    chk("iresp", 128'(iresp), 128'(ei));
    chk("dresp", 128'(dresp), 128'(ed));
    if (iresp.addr_ok) grant_log.push_back(CH_I);
    if (dresp.addr_ok) grant_log.push_back(CH_D);
    s_creq  = creq;
    s_iresp = iresp;
    s_dresp = dresp;
    if (gi || gd) begin
      if (hs) begin
        if (gi) m_streak = 0;
        else    m_streak = ireq.valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        m_owner    = dok ? 0 : ow;
        m_accepted = !dok;
      end else begin
        m_owner    = ow;
        m_accepted = 1'b0;
      end
    end else if (m_accepted && dok) begin
      m_owner    = 0;
      m_accepted = 1'b0;
    end
    nb = mem_busy;
    na = mem_addr_q;
    if (cresp.addr_ok && !cresp.data_ok) begin
      nb = 1'b1;
      na = creq.addr;
    end else if (mem_busy && cresp.data_ok) begin
      nb = 1'b0;
    end
    iack = iresp.addr_ok;
    dack = dresp.addr_ok;
    @(posedge clk);
    #1;
    mem_busy   = nb;
    mem_addr_q = na;
    if (iack) ireq.valid = 1'b0;
    if (dack) dreq.valid = 1'b0;
    chk("streak", 128'(dbg_streak), 128'(m_streak));
  endtask

  task automatic apply_reset();
    resetn   = 1'b0;
    ireq     = '0;
    dreq     = '0;
    mem_aok  = 1'b0;
    mem_dok  = 1'b0;
    mem_same = 1'b0;
    @(posedge clk);
    #1;
    mem_busy   = 1'b0;
    m_owner    = 0;
    m_accepted = 1'b0;
    m_streak   = 0;
    exp_q_i.delete();
    exp_q_d.delete();
    chk("rst_state", 128'(dbg_state), 128'(IDLE));
    chk("rst_streak", 128'(dbg_streak), 128'(0));
    chk("rst_creq", 128'(creq), 128'(0));
    chk("rst_iresp", 128'(iresp), 128'(0));
    chk("rst_dresp", 128'(dresp), 128'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n       = 0;
    mem_aok = 1'b1;
    mem_dok = 1'b1;
    while ((ireq.valid || dreq.valid || m_owner != 0) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 128'(ireq.valid || dreq.valid || m_owner != 0), 128'(0));
  endtask

  initial begin
    cbus_req_t  ec;
    dbus_resp_t er;
    string      exp_order;

    // Reset
    apply_reset();

    // Lone instruction fetch, data_ok two cycles after addr_ok
    ireq     = '{valid: 1'b1, addr: 32'hbfc0_0000};
    mem_aok  = 1'b1;
    mem_dok  = 1'b0;
    tick();
    ec = '{valid: 1'b1, is_write: 1'b0, addr: 32'hbfc0_0000, size: 3'b010, strobe: 4'h0, data: 32'h0};
    chk("ifetch_creq", 128'(s_creq), 128'(ec));
    chk("ifetch_dresp0", 128'(s_dresp), 128'(0));
    tick();
    chk("ifetch_wait", 128'(s_iresp), 128'(0));
    mem_dok = 1'b1;
    tick();
    chk("ifetch_data_ok", 128'(s_iresp.data_ok), 128'(1));
    chk("ifetch_data", 128'(s_iresp.data), 128'(32'h2408_0001));
    chk("ifetch_dresp2", 128'(s_dresp), 128'(0));
    tick();
    chk("ifetch_pulse", 128'(s_iresp.data_ok), 128'(0));

    // Collision: dbus store wins, ibus follows after dbus data_ok
    ireq    = '{valid: 1'b1, addr: 32'h0000_1000};
    dreq    = '{valid: 1'b1, addr: 32'h8000_0010, size: SIZE_WORD, strobe: 4'hf, data: 32'hdead_beef};
    mem_aok = 1'b1;
    mem_dok = 1'b0;
    tick();
    chk("coll_dgrant", 128'(s_dresp.addr_ok), 128'(1));
    chk("coll_write", 128'(s_creq.is_write), 128'(1));
    chk("coll_iwait", 128'(s_iresp.addr_ok), 128'(0));
    mem_dok = 1'b1;
    tick();
    chk("coll_ddata", 128'(s_dresp.data_ok), 128'(1));
    chk("coll_iwait2", 128'(s_iresp.addr_ok), 128'(0));
    tick();
    chk("coll_igrant", 128'(s_iresp.addr_ok), 128'(1));
    drain("coll_drain");

    // Starvation bound: ibus held, dbus re-requests every cycle
    grant_log.delete();
    mem_aok  = 1'b1;
    mem_dok  = 1'b1;
    mem_same = 1'b0;
    for (int n = 0; n < 60 && grant_log.size() < 10; n++) begin
      if (!ireq.valid) ireq = '{valid: 1'b1, addr: 32'h0000_4000};
      if (!dreq.valid) dreq = '{valid: 1'b1, addr: 32'h0000_0100 + 32'(n * 4), size: SIZE_WORD,
                                strobe: 4'h0, data: 32'h0};
      tick();
    end
    exp_order = "DDDDIDDDDI";
    chk("starve_count", 128'(grant_log.size()), 128'(10));
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk("starve_order", 128'(grant_log[i]), 128'(exp_order[i]));
    drain("starve_drain");

    // Lock: addr_ok withheld for 3 cycles, dbus arrives in cycle 1
    ireq    = '{valid: 1'b1, addr: 32'h0000_2000};
    mem_dok = 1'b0;
    ec      = '{valid: 1'b1, is_write: 1'b0, addr: 32'h0000_2000, size: 3'b010, strobe: 4'h0, data: 32'h0};
    for (int c = 0; c < 4; c++) begin
      if (c == 1) dreq = '{valid: 1'b1, addr: 32'h0000_3000, size: SIZE_WORD, strobe: 4'h0, data: 32'h0};
      mem_aok = (c == 3);
      tick();
      chk("lock_creq", 128'(s_creq), 128'(ec));
      chk("lock_dack", 128'(s_dresp.addr_ok), 128'(0));
    end
    mem_dok = 1'b1;
    tick();
    chk("lock_idata", 128'(s_iresp.data_ok), 128'(1));
    chk("lock_dack_data", 128'(s_dresp.addr_ok), 128'(0));
    tick();
    chk("lock_dgrant", 128'(s_dresp.addr_ok), 128'(1));
    drain("lock_drain");

    // Same-cycle addr_ok + data_ok: one dbus load per cycle
    mem_aok  = 1'b1;
    mem_dok  = 1'b0;
    mem_same = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dreq = '{valid: 1'b1, addr: 32'(k * 4), size: SIZE_WORD, strobe: 4'h0, data: 32'h0};
      tick();
      er = '{addr_ok: 1'b1, data_ok: 1'b1, data: mem_word(32'(k * 4))};
      chk("same_dresp", 128'(s_dresp), 128'(er));
      chk("same_state", 128'(dbg_state), 128'(IDLE));
    end
    mem_same = 1'b0;

    // Reset while in D_DATA, then a fresh fetch
    dreq = '{valid: 1'b1, addr: 32'h0000_0040, size: SIZE_WORD, strobe: 4'h0, data: 32'h0};
    tick();
    chk("mid_state", 128'(dbg_state), 128'(D_DATA));
    apply_reset();
    ireq    = '{valid: 1'b1, addr: 32'h0000_3000};
    mem_aok = 1'b1;
    tick();
    chk("post_rst_grant", 128'(s_iresp.addr_ok), 128'(1));
    drain("post_rst_drain");

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      if (!ireq.valid && $urandom_range(0, 2) != 0) begin
        ireq.valid = 1'b1;
        ireq.addr  = $urandom & 32'hffff_fffc;
      end
      if (!dreq.valid && $urandom_range(0, 1) == 0) begin
        dreq.valid  = 1'b1;
        dreq.addr   = $urandom;
        dreq.size   = 3'($urandom_range(0, 2));
        dreq.strobe = 4'($urandom);
        dreq.data   = $urandom;
      end
      mem_aok  = ($urandom_range(0, 3) != 0);
      mem_dok  = ($urandom_range(0, 2) != 0);
      mem_same = ($urandom_range(0, 3) == 0);
      tick();
    end
    mem_same = 1'b0;
    drain("rand_drain");
    chk("queues_empty", 128'(exp_q_i.size() + exp_q_d.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
